// File: rtl/ysyx_23060236_lsu_pkg.sv
// Shared encodings for the load/store unit:
// funct3 sizes, AXI response codes and FSM states.
package ysyx_23060236_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } lsu_state_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060236_lsu_align.sv
// Byte-lane steering: store data/strobe shifter and
// load extractor with sign/zero extension.
module ysyx_23060236_lsu_align
    import ysyx_23060236_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    logic [4:0]  sh_amt;
    logic [31:0] ld_sh;
    logic [3:0]  base;

    assign sh_amt   = {offset, 3'b000};
    assign st_wdata = st_data << sh_amt;
    assign ld_sh    = ld_raw >> sh_amt;
    assign st_wstrb = base << offset;

    // Strobe pattern for the access size before lane shifting
    always_comb begin
        base = 4'b1111;
        case (funct3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    // Extend the shifted-down load to a full register value
    always_comb begin
        ld_data = ld_sh;
        case (funct3)
            LSU_B:   ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            LSU_H:   ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            LSU_BU:  ld_data = {24'h0, ld_sh[7:0]};
            LSU_HU:  ld_data = {16'h0, ld_sh[15:0]};
            default: ld_data = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_23060236_lsu.sv
// Load/store unit: runs one execute-stage request on an
// AXI4-Lite master port and pulses lsu_over on completion.
module ysyx_23060236_lsu
    import ysyx_23060236_lsu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              exu_fire,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    input  logic              req_reg_wen,
    output logic              lsu_over,
    output logic              lsu_fault,
    output logic [4:0]        wb_rd,
    output logic              wb_wen,
    output logic [31:0]       wb_data,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_t  state, state_n;
    logic        aw_done, aw_done_n;
    logic        w_done, w_done_n;
    logic        fault_q, fault_n;
    logic [31:0] ld_q, ld_n;
    logic [31:0] al_wdata, al_ld;
    logic [3:0]  al_wstrb;
    logic [31:0] addr32;
    logic        mis;

    assign addr32 = 32'(req_addr);
    assign mis    = MISALIGN_CHK &&
                    is_misaligned(req_funct3[1:0], req_addr[1:0]);

    ysyx_23060236_lsu_align u_align (
        .funct3   (req_funct3),
        .offset   (req_addr[1:0]),
        .st_data  (req_wdata),
        .ld_raw   (rdata),
        .st_wdata (al_wdata),
        .st_wstrb (al_wstrb),
        .ld_data  (al_ld)
    );

    assign araddr = req_addr;
    assign awaddr = req_addr;
    assign wdata  = al_wdata;
    assign wstrb  = al_wstrb;

    assign lsu_over  = state == S_DONE;
    assign lsu_fault = lsu_over & fault_q;
    assign wb_rd     = lsu_over ? req_rd : 5'd0;
    assign wb_wen    = lsu_over & req_reg_wen & ~fault_q & ~req_wen;
    assign wb_data   = !lsu_over ? 32'd0 :
                       req_ren   ? ld_q  : addr32;

    // State, channel-done flags, fault and load data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            fault_q <= 1'b0;
            ld_q    <= 32'd0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            fault_q <= fault_n;
            ld_q    <= ld_n;
        end
    end

    // Next state and AXI handshake outputs
    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        fault_n   = fault_q;
        ld_n      = ld_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state)
            S_IDLE: begin
                if (exu_fire) begin
                    fault_n   = 1'b0;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    if ((req_ren || req_wen) && mis) begin
                        fault_n = 1'b1;
                        state_n = S_DONE;
                    end else if (req_ren) begin
                        state_n = S_AR;
                    end else if (req_wen) begin
                        state_n = S_WR;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_n = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    ld_n    = al_ld;
                    fault_n = rresp != AXI_OKAY;
                    state_n = S_DONE;
                end
            end
            S_WR: begin
                awvalid   = !aw_done;
                wvalid    = !w_done;
                aw_done_n = aw_done | awready;
                w_done_n  = w_done | wready;
                if (aw_done_n && w_done_n) state_n = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    fault_n = bresp != AXI_OKAY;
                    state_n = S_DONE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // A new instruction while busy means the execute stage broke protocol
    always @(posedge clock) begin
        if (!reset) assert (!exu_fire || state == S_IDLE);
    end

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Randomized bench for ysyx_23060236_lsu with an AXI slave
// and a byte-lane reference model of every completion.
`timescale 1ns/1ps
module tb_ysyx_23060236_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        exu_fire;
    logic        req_ren, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        req_reg_wen;
    logic        lsu_over, lsu_fault;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    ysyx_23060236_lsu #(.ADDR_W(32), .MISALIGN_CHK(1'b1)) dut (
        .clock(clock), .reset(reset), .exu_fire(exu_fire),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .req_rd(req_rd), .req_reg_wen(req_reg_wen),
        .lsu_over(lsu_over), .lsu_fault(lsu_fault), .wb_rd(wb_rd),
        .wb_wen(wb_wen), .wb_data(wb_data),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        bit          wen;
        logic [4:0]  rd;
        bit          fault;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    int ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0, valid_cyc = 0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
    logic [3:0]  exp_wstrb = 4'd0;
    logic [31:0] last_data = 32'd0, last_wdata = 32'd0;
    logic [3:0]  last_wstrb = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w,
                                           input logic [1:0] a,
                                           input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            if (int'(a) + i < 4) v[8*i +: 8] = w[8*(int'(a) + i) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input int n, input logic [1:0] a);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < n; i++)
            if (int'(a) + i < 4) s[int'(a) + i] = 1'b1;
        return s;
    endfunction

    // AXI slave: each ready/valid follows the master after a set delay
    initial begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 32'd0; rresp = 2'b00; bresp = 2'b00;
        forever begin
            @(negedge clock);
            arready = arvalid && ar_cnt >= ar_d;
            ar_cnt = (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (arready) begin
                ar_hs++;
                chk("araddr", araddr, exp_addr);
            end
            rvalid = rready && r_cnt >= r_d;
            r_cnt = (rready && !rvalid) ? r_cnt + 1 : 0;
            rdata = rvalid ? s_rdata : 32'hDEADBEEF;
            rresp = rvalid ? s_rresp : 2'b00;
            awready = awvalid && aw_cnt >= aw_d;
            aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;
            if (awready) begin
                aw_hs++;
                chk("awaddr", awaddr, exp_addr);
            end
            wready = wvalid && w_cnt >= w_d;
            w_cnt = (wvalid && !wready) ? w_cnt + 1 : 0;
            if (wready) begin
                w_hs++;
                last_wdata = wdata;
                last_wstrb = wstrb;
                chk("wdata", wdata, exp_wdata);
                chk("wstrb", {28'd0, wstrb}, {28'd0, exp_wstrb});
            end
            bvalid = bready && b_cnt >= b_d;
            b_cnt = (bready && !bvalid) ? b_cnt + 1 : 0;
            bresp = bvalid ? s_bresp : 2'b00;
            if (arvalid || awvalid || wvalid) valid_cyc++;
        end
    end

    // Compare every completion pulse against the model queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && lsu_over) begin
                chk("over_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    last_data = wb_data;
                    chk("wb_wen", {31'd0, wb_wen}, {31'd0, e.wen});
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("lsu_fault", {31'd0, lsu_fault}, {31'd0, e.fault});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic run_op(input bit ren, input bit wen,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input bit rw, input logic [31:0] rdv,
                          input logic [1:0] resp, input int d_a,
                          input int d_d, input int d_r);
        int n, lat, cyc;
        bit isld, isst, mis, flt, got;
        logic [1:0] a;
        exp_t e;
        a = addr[1:0];
        n = size_of(f3);
        isld = ren;
        isst = wen && !ren;
        mis = (isld || isst) && ((n == 2 && a[0]) || (n == 4 && a != 2'b00));
        flt = mis || (isld && resp != 2'b00) || (isst && resp != 2'b00);
        e.data = isld ? m_load(rdv, a, f3) : addr;
        e.chk_data = !isst && !flt;
        e.wen = rw && !flt && !wen;
        e.rd = rd;
        e.fault = flt;
        if (mis || !(isld || isst)) lat = 1;
        else if (isld) lat = 3 + d_a + d_r;
        else lat = 3 + ((d_a > d_d) ? d_a : d_d) + d_r;
        @(negedge clock);
        ar_d = d_a; aw_d = d_a; w_d = d_d; r_d = d_r; b_d = d_r;
        s_rdata = rdv; s_rresp = resp; s_bresp = resp;
        exp_addr = addr;
        exp_wdata = wd << (8 * int'(a));
        exp_wstrb = m_strb(n, a);
        ar_hs = 0; aw_hs = 0; w_hs = 0; valid_cyc = 0;
        exp_q.push_back(e);
        req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wd;
        req_funct3 = f3; req_rd = rd; req_reg_wen = rw;
        exu_fire = 1'b1;
        cyc = 0;
        got = 0;
        while (cyc < 100 && !got) begin
            @(negedge clock);
            exu_fire = 1'b0;
            cyc++;
            got = lsu_over;
        end
        chk("latency", cyc, lat);
        chk("ar_count", ar_hs, {31'd0, isld && !mis});
        chk("aw_count", aw_hs, {31'd0, isst && !mis});
        chk("w_count", w_hs, {31'd0, isst && !mis});
        if (mis || !(isld || isst)) chk("no_bus_valid", valid_cyc, 0);
        if (!got) begin
            exp_q.delete();
            reset = 1'b1;
            repeat (2) @(negedge clock);
            reset = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        int kind, n;
        bit ren_r, wen_r;
        logic [2:0]  f3_r;
        logic [31:0] a_r;
        logic [1:0]  rs_r;

        reset = 1'b1; exu_fire = 1'b0;
        req_ren = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        req_funct3 = 0; req_rd = 0; req_reg_wen = 0;
        repeat (3) @(negedge clock);
        chk("rst_ctrl", {24'd0, lsu_over, lsu_fault, wb_wen, arvalid,
                         rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b0;

        run_op(0, 0, 32'h12345678, 0, 3'b010, 5'd5, 1, 0, 2'b00, 0, 0, 0);
        chk("nonmem_data", last_data, 32'h12345678);

        chk("model_lb", m_load(32'h80FF7F01, 2'd3, 3'b000), 32'hFFFFFF80);
        run_op(1, 0, 32'h80000003, 0, 3'b000, 5'd7, 1, 32'h80FF7F01,
               2'b00, 0, 0, 2);
        chk("lb_data", last_data, 32'hFFFFFF80);
        run_op(1, 0, 32'h80000003, 0, 3'b100, 5'd8, 1, 32'h80FF7F01,
               2'b00, 1, 0, 2);
        chk("lbu_data", last_data, 32'h00000080);

        chk("model_sh_strb", {28'd0, m_strb(2, 2'd2)}, 32'h0000000C);
        run_op(0, 1, 32'h80000002, 32'h0000BEEF, 3'b001, 5'd0, 0, 0,
               2'b00, 0, 3, 1);
        chk("sh_wdata", last_wdata, 32'hBEEF0000);
        chk("sh_wstrb", {28'd0, last_wstrb}, 32'h0000000C);

        run_op(0, 1, 32'h80000010, 32'hCAFEF00D, 3'b010, 5'd0, 0, 0,
               2'b00, 0, 0, 0);
        chk("sw_wdata", last_wdata, 32'hCAFEF00D);

        run_op(1, 0, 32'h80000002, 0, 3'b010, 5'd9, 1, 32'h11111111,
               2'b00, 0, 0, 0);
        run_op(1, 0, 32'h80000004, 0, 3'b010, 5'd9, 1, 32'h11111111,
               2'b10, 0, 0, 0);

        // reset while the read data phase is stalled
        @(negedge clock);
        ar_d = 0; r_d = 1000;
        exp_addr = 32'h80000100;
        req_ren = 1; req_wen = 0; req_addr = 32'h80000100;
        req_funct3 = 3'b010; req_rd = 5'd3; req_reg_wen = 1;
        exu_fire = 1'b1;
        @(negedge clock);
        exu_fire = 1'b0;
        for (int i = 0; i < 20 && !rready; i++) @(negedge clock);
        chk("reached_r", {31'd0, rready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid", {29'd0, rready, arvalid, lsu_over}, 32'd0);
        reset = 1'b0;
        r_d = 0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_no_over", {31'd0, lsu_over}, 32'd0);
        end
        run_op(0, 0, 32'hA5A5_0001, 0, 3'b000, 5'd31, 1, 0, 2'b00, 0, 0, 0);
        chk("post_rst_data", last_data, 32'hA5A50001);

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 2);
            ren_r = kind == 1;
            wen_r = kind == 2;
            f3_r = wen_r ? f3tab[$urandom_range(0, 2)]
                         : f3tab[$urandom_range(0, 4)];
            a_r = $urandom;
            n = size_of(f3_r);
            if ($urandom_range(0, 3) != 0) begin
                if (n == 2) a_r[0] = 1'b0;
                if (n == 4) a_r[1:0] = 2'b00;
            end
            rs_r = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3))
                                               : 2'b00;
            run_op(ren_r, wen_r, a_r, $urandom, f3_r, 5'($urandom),
                   1'($urandom), $urandom, rs_r, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
